// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: MIPS-I opcode/funct encodings,
// the 4-bit ALU operation encoding, register-file geometry and the
// decoded bundle handed to execute.
package decode_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct codes (ir[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation encoding seen by execute
  localparam logic [OP_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB    = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND    = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR     = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR    = 4'd4;
  localparam logic [OP_W-1:0] ALU_NOR    = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT    = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLTU   = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLL    = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRL    = 4'd9;
  localparam logic [OP_W-1:0] ALU_SRA    = 4'd10;
  localparam logic [OP_W-1:0] ALU_LUI    = 4'd11;
  localparam logic [OP_W-1:0] ALU_PASS_A = 4'd12;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  // Decoded bundle registered into the execute stage; all-zero is a NOP
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] st;
    logic [REG_AW-1:0] dest;
    logic              wen;
    logic              mem_rd;
    logic              mem_wr;
    logic              illegal;
  } id_bundle_t;

  function automatic logic [WORD_W-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [WORD_W-1:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port with write-through bypass so a same-cycle read sees the write data.
// r0 always reads zero. Contents are not reset; writes are ignored while
// rst is low.
//   clk, rst           clock, synchronous active-low reset (write gate)
//   we/waddr/wdata     write port from writeback
//   ra_addr/ra_data    read port A (rs)
//   rb_addr/rb_data    read port B (rt)
module decode_regfile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [WORD_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [WORD_W-1:0] rb_data
);

  logic [WORD_W-1:0] mem [32];
  logic              wr_ok;

  assign wr_ok = rst && we && (waddr != REG_ZERO);

  // Storage write; no reset on the array itself
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports with zero register and write-through bypass
  always_comb begin
    ra_data = mem[ra_addr];
    rb_data = mem[rb_addr];
    if (ra_addr == REG_ZERO)                  ra_data = '0;
    else if (wr_ok && (waddr == ra_addr))     ra_data = wdata;
    if (rb_addr == REG_ZERO)                  rb_data = '0;
    else if (wr_ok && (waddr == rb_addr))     rb_data = wdata;
  end

endmodule

// File: rtl/decode.sv
// MIPS-I decode stage. Reads operands (with ex/wb forwarding), builds the
// registered bundle for execute and resolves jumps/branches combinationally
// back to fetch. Delay slots are never annulled; decode never stalls.
//   clk, rst                     clock, synchronous active-low reset
//   pc, ir                       fetch PC (address of ir + 1), instruction
//   jump, target                 combinational redirect to fetch
//   wb_wen/wb_addr/wb_data       register-file write port
//   ex_wen/ex_addr/ex_data       execute result for forwarding
//   id_*                         registered bundle to execute
module decode
  import decode_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32   // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] pc,
  input  logic [WORD_WIDTH-1:0] ir,
  output logic                  jump,
  output logic [WORD_WIDTH-1:0] target,
  input  logic                  wb_wen,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic [WORD_WIDTH-1:0] wb_data,
  input  logic                  ex_wen,
  input  logic [REG_AW-1:0]     ex_addr,
  input  logic [WORD_WIDTH-1:0] ex_data,
  output logic [OP_W-1:0]       id_op,
  output logic [WORD_WIDTH-1:0] id_a,
  output logic [WORD_WIDTH-1:0] id_b,
  output logic [WORD_WIDTH-1:0] id_st,
  output logic [REG_AW-1:0]     id_dest,
  output logic                  id_wen,
  output logic                  id_mem_rd,
  output logic                  id_mem_wr,
  output logic                  id_illegal
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic [REG_AW-1:0]     rs;
  logic [REG_AW-1:0]     rt;
  logic [REG_AW-1:0]     rd;
  logic [15:0]           imm;
  logic [25:0]           jidx;

  logic [WORD_WIDTH-1:0] rf_rs;
  logic [WORD_WIDTH-1:0] rf_rt;
  logic [WORD_WIDTH-1:0] rs_val;
  logic [WORD_WIDTH-1:0] rt_val;
  logic [WORD_WIDTH-1:0] link;
  logic [WORD_WIDTH-1:0] br_tgt;

  id_bundle_t            nxt;
  id_bundle_t            id_q;
  logic [REG_AW-1:0]     dest;
  logic                  illegal;
  logic                  jump_raw;
  logic [WORD_WIDTH-1:0] tgt_raw;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign jidx   = ir[25:0];

  // pc already points past ir, so pc+1 skips the delay slot
  assign link   = pc + 32'd1;
  assign br_tgt = pc + sext16(imm);

  decode_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_wen),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .ra_addr (rs),
    .ra_data (rf_rs),
    .rb_addr (rt),
    .rb_data (rf_rt)
  );

  // Operand select: r0, then ex forward, then regfile (which carries the wb bypass)
  always_comb begin
    rs_val = rf_rs;
    rt_val = rf_rt;
    if (rs == REG_ZERO)                  rs_val = '0;
    else if (ex_wen && (ex_addr == rs))  rs_val = ex_data;
    if (rt == REG_ZERO)                  rt_val = '0;
    else if (ex_wen && (ex_addr == rt))  rt_val = ex_data;
  end

  // Instruction decode and redirect resolution
  always_comb begin
    nxt      = '0;
    nxt.a    = rs_val;
    nxt.b    = rt_val;
    nxt.st   = rt_val;
    dest     = REG_ZERO;
    illegal  = 1'b0;
    jump_raw = 1'b0;
    tgt_raw  = '0;
    unique case (opcode)
      OPC_SPECIAL: begin
        unique case (funct)
          FN_SLL:  begin nxt.op = ALU_SLL; nxt.a = {27'b0, shamt}; dest = rd; end
          FN_SRL:  begin nxt.op = ALU_SRL; nxt.a = {27'b0, shamt}; dest = rd; end
          FN_SRA:  begin nxt.op = ALU_SRA; nxt.a = {27'b0, shamt}; dest = rd; end
          FN_JR:   begin jump_raw = 1'b1; tgt_raw = rs_val; end
          FN_JALR: begin
            jump_raw = 1'b1;
            tgt_raw  = rs_val;
            nxt.op   = ALU_PASS_A;
            nxt.a    = link;
            dest     = rd;
          end
          FN_ADDU: begin nxt.op = ALU_ADD;  dest = rd; end
          FN_SUBU: begin nxt.op = ALU_SUB;  dest = rd; end
          FN_AND:  begin nxt.op = ALU_AND;  dest = rd; end
          FN_OR:   begin nxt.op = ALU_OR;   dest = rd; end
          FN_XOR:  begin nxt.op = ALU_XOR;  dest = rd; end
          FN_NOR:  begin nxt.op = ALU_NOR;  dest = rd; end
          FN_SLT:  begin nxt.op = ALU_SLT;  dest = rd; end
          FN_SLTU: begin nxt.op = ALU_SLTU; dest = rd; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_J: begin
        jump_raw = 1'b1;
        tgt_raw  = {pc[31:26], jidx};
      end
      OPC_JAL: begin
        jump_raw = 1'b1;
        tgt_raw  = {pc[31:26], jidx};
        nxt.op   = ALU_PASS_A;
        nxt.a    = link;
        dest     = REG_RA;
      end
      OPC_BEQ: begin
        nxt.op = ALU_SUB;
        if (rs_val == rt_val) begin jump_raw = 1'b1; tgt_raw = br_tgt; end
      end
      OPC_BNE: begin
        nxt.op = ALU_SUB;
        if (rs_val != rt_val) begin jump_raw = 1'b1; tgt_raw = br_tgt; end
      end
      OPC_ADDIU: begin nxt.op = ALU_ADD;  nxt.b = sext16(imm); dest = rt; end
      OPC_SLTI:  begin nxt.op = ALU_SLT;  nxt.b = sext16(imm); dest = rt; end
      OPC_SLTIU: begin nxt.op = ALU_SLTU; nxt.b = sext16(imm); dest = rt; end
      OPC_ANDI:  begin nxt.op = ALU_AND;  nxt.b = zext16(imm); dest = rt; end
      OPC_ORI:   begin nxt.op = ALU_OR;   nxt.b = zext16(imm); dest = rt; end
      OPC_XORI:  begin nxt.op = ALU_XOR;  nxt.b = zext16(imm); dest = rt; end
      OPC_LUI:   begin nxt.op = ALU_LUI;  nxt.b = {imm, 16'h0000}; dest = rt; end
      OPC_LW: begin
        nxt.op     = ALU_ADD;
        nxt.b      = sext16(imm);
        nxt.mem_rd = 1'b1;
        dest       = rt;
      end
      OPC_SW: begin
        nxt.op     = ALU_ADD;
        nxt.b      = sext16(imm);
        nxt.mem_wr = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    nxt.dest = dest;
    nxt.wen  = (dest != REG_ZERO);

    // Reserved encodings become a flagged NOP with no redirect
    if (illegal) begin
      nxt         = '0;
      nxt.illegal = 1'b1;
      jump_raw    = 1'b0;
      tgt_raw     = '0;
    end
  end

  // Decode-to-execute pipeline register
  always_ff @(posedge clk) begin
    if (!rst) id_q <= '0;
    else      id_q <= nxt;
  end

  assign jump   = rst && jump_raw;
  assign target = jump ? tgt_raw : '0;

  assign id_op      = id_q.op;
  assign id_a       = id_q.a;
  assign id_b       = id_q.b;
  assign id_st      = id_q.st;
  assign id_dest    = id_q.dest;
  assign id_wen     = id_q.wen;
  assign id_mem_rd  = id_q.mem_rd;
  assign id_mem_wr  = id_q.mem_wr;
  assign id_illegal = id_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage with hand-computed expectations.
module tb_decode;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        jump;
  logic [31:0] target;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_wen;
  logic [4:0]  ex_addr;
  logic [31:0] ex_data;
  logic [3:0]  id_op;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [31:0] id_st;
  logic [4:0]  id_dest;
  logic        id_wen;
  logic        id_mem_rd;
  logic        id_mem_wr;
  logic        id_illegal;

  int total;
  int bad;

  decode #(.WORD_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ir         (ir),
    .jump       (jump),
    .target     (target),
    .wb_wen     (wb_wen),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_wen     (ex_wen),
    .ex_addr    (ex_addr),
    .ex_data    (ex_data),
    .id_op      (id_op),
    .id_a       (id_a),
    .id_b       (id_b),
    .id_st      (id_st),
    .id_dest    (id_dest),
    .id_wen     (id_wen),
    .id_mem_rd  (id_mem_rd),
    .id_mem_wr  (id_mem_wr),
    .id_illegal (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    wb_wen  = 1'b1;
    wb_addr = a;
    wb_data = d;
    ir      = 32'h0;
    step();
    wb_wen  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pc  = 32'h8000_0041;
    ir  = 32'h0C00_0100;   // JAL: would redirect if not in reset
    #1;
    total++; if (jump !== 1'b0) begin bad++; $display("FAIL rst_jump got=%b exp=0", jump); end
    total++; if (target !== 32'h0) begin bad++; $display("FAIL rst_target got=%h exp=00000000", target); end
    step(); step();
    total++; if (id_op !== 4'd0) begin bad++; $display("FAIL rst_id_op got=%h exp=0", id_op); end
    total++; if (id_a !== 32'h0 || id_b !== 32'h0 || id_st !== 32'h0) begin
      bad++; $display("FAIL rst_operands got a=%h b=%h st=%h exp all 0", id_a, id_b, id_st); end
    total++; if ({id_dest, id_wen, id_mem_rd, id_mem_wr, id_illegal} !== 9'h0) begin
      bad++; $display("FAIL rst_ctrl got dest=%h wen=%b rd=%b wr=%b ill=%b exp 0",
                      id_dest, id_wen, id_mem_rd, id_mem_wr, id_illegal); end
    rst = 1'b1;
    ir  = 32'h0;
    step();
  endtask

  task automatic test_write_through();
    // ADDU r3,r5,r0 while wb writes r5 in the same cycle
    wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    ir = 32'h00A0_1821;
    step();
    wb_wen = 1'b0;
    total++; if (id_a !== 32'h0000_1234) begin bad++; $display("FAIL wt_id_a got=%h exp=00001234", id_a); end
    total++; if (id_dest !== 5'd3) begin bad++; $display("FAIL wt_id_dest got=%0d exp=3", id_dest); end
    total++; if (id_wen !== 1'b1) begin bad++; $display("FAIL wt_id_wen got=%b exp=1", id_wen); end
    total++; if (id_op !== 4'd0 || id_b !== 32'h0) begin
      bad++; $display("FAIL wt_op_b got op=%h b=%h exp op=0 b=0", id_op, id_b); end
    // Committed value persists once the bypass is gone
    step();
    total++; if (id_a !== 32'h0000_1234) begin bad++; $display("FAIL wt_commit got=%h exp=00001234", id_a); end
  endtask

  task automatic test_branch();
    wr_reg(5'd1, 32'd7);
    wr_reg(5'd2, 32'd7);
    pc = 32'h0000_0010;
    ir = 32'h1022_FFFC;   // BEQ r1,r2,-4
    #1;
    total++; if (jump !== 1'b1) begin bad++; $display("FAIL beq_taken_jump got=%b exp=1", jump); end
    total++; if (target !== 32'h0000_000C) begin bad++; $display("FAIL beq_taken_target got=%h exp=0000000c", target); end
    step();
    wr_reg(5'd2, 32'd8);
    pc = 32'h0000_0010;
    ir = 32'h1022_FFFC;
    #1;
    total++; if (jump !== 1'b0) begin bad++; $display("FAIL beq_nt_jump got=%b exp=0", jump); end
    total++; if (target !== 32'h0) begin bad++; $display("FAIL beq_nt_target got=%h exp=00000000", target); end
    ir = 32'h1422_FFFC;   // BNE r1,r2,-4
    #1;
    total++; if (jump !== 1'b1 || target !== 32'h0000_000C) begin
      bad++; $display("FAIL bne_taken got jump=%b target=%h exp 1/0000000c", jump, target); end
    // ex forward makes r2 look like 7 again
    ex_wen = 1'b1; ex_addr = 5'd2; ex_data = 32'd7;
    ir = 32'h1022_FFFC;
    #1;
    total++; if (jump !== 1'b1 || target !== 32'h0000_000C) begin
      bad++; $display("FAIL beq_fwd got jump=%b target=%h exp 1/0000000c", jump, target); end
    ex_wen = 1'b0;
    step();
  endtask

  task automatic test_jal();
    pc = 32'h8000_0041;
    ir = 32'h0C00_0100;   // JAL 0x100
    #1;
    total++; if (jump !== 1'b1) begin bad++; $display("FAIL jal_jump got=%b exp=1", jump); end
    total++; if (target !== 32'h8000_0100) begin bad++; $display("FAIL jal_target got=%h exp=80000100", target); end
    step();
    ir = 32'h0;
    total++; if (id_dest !== 5'd31 || id_wen !== 1'b1) begin
      bad++; $display("FAIL jal_dest got dest=%0d wen=%b exp 31/1", id_dest, id_wen); end
    total++; if (id_a !== 32'h8000_0042) begin bad++; $display("FAIL jal_link got=%h exp=80000042", id_a); end
    total++; if (id_op !== 4'd12) begin bad++; $display("FAIL jal_op got=%0d exp=12", id_op); end
  endtask

  task automatic test_forward();
    ex_wen = 1'b1; ex_addr = 5'd4; ex_data = 32'd1;
    wb_wen = 1'b1; wb_addr = 5'd4; wb_data = 32'd2;
    ir = 32'h0080_0008;   // JR r4
    #1;
    total++; if (jump !== 1'b1 || target !== 32'd1) begin
      bad++; $display("FAIL fwd_ex_wins got jump=%b target=%h exp 1/00000001", jump, target); end
    ex_wen = 1'b0;
    #1;
    total++; if (target !== 32'd2) begin bad++; $display("FAIL fwd_wb got=%h exp=00000002", target); end
    step();
    wb_wen = 1'b0;
    #1;
    total++; if (target !== 32'd2) begin bad++; $display("FAIL fwd_rf got=%h exp=00000002", target); end
    ex_wen = 1'b1; ex_addr = 5'd0; ex_data = 32'd5;
    ir = 32'h0000_0008;   // JR r0
    #1;
    total++; if (jump !== 1'b1 || target !== 32'h0) begin
      bad++; $display("FAIL fwd_r0 got jump=%b target=%h exp 1/00000000", jump, target); end
    ex_wen = 1'b0;
    step();
  endtask

  task automatic test_imm();
    ir = 32'h3406_8001;   // ORI r6,r0,0x8001
    step();
    total++; if (id_b !== 32'h0000_8001 || id_op !== 4'd3 || id_dest !== 5'd6) begin
      bad++; $display("FAIL ori got b=%h op=%0d dest=%0d exp 00008001/3/6", id_b, id_op, id_dest); end
    ir = 32'h2407_8001;   // ADDIU r7,r0,0x8001
    step();
    total++; if (id_b !== 32'hFFFF_8001 || id_op !== 4'd0 || id_a !== 32'h0) begin
      bad++; $display("FAIL addiu got b=%h op=%0d a=%h exp ffff8001/0/0", id_b, id_op, id_a); end
    ir = 32'h3C08_1234;   // LUI r8,0x1234
    step();
    total++; if (id_b !== 32'h1234_0000 || id_op !== 4'd11 || id_dest !== 5'd8) begin
      bad++; $display("FAIL lui got b=%h op=%0d dest=%0d exp 12340000/11/8", id_b, id_op, id_dest); end
    ir = 32'h0005_48C0;   // SLL r9,r5,3
    step();
    total++; if (id_a !== 32'd3 || id_b !== 32'h0000_1234 || id_op !== 4'd8 || id_dest !== 5'd9) begin
      bad++; $display("FAIL sll got a=%h b=%h op=%0d dest=%0d exp 3/1234/8/9", id_a, id_b, id_op, id_dest); end
    ir = 32'h8CAA_FFF8;   // LW r10,-8(r5)
    step();
    total++; if (id_a !== 32'h0000_1234 || id_b !== 32'hFFFF_FFF8 || id_op !== 4'd0) begin
      bad++; $display("FAIL lw_ops got a=%h b=%h op=%0d exp 1234/fffffff8/0", id_a, id_b, id_op); end
    total++; if (id_dest !== 5'd10 || id_wen !== 1'b1 || id_mem_rd !== 1'b1 || id_mem_wr !== 1'b0) begin
      bad++; $display("FAIL lw_ctrl got dest=%0d wen=%b rd=%b wr=%b exp 10/1/1/0", id_dest, id_wen, id_mem_rd, id_mem_wr); end
    ir = 32'hAC25_0004;   // SW r5,4(r1)
    step();
    total++; if (id_a !== 32'd7 || id_b !== 32'd4 || id_st !== 32'h0000_1234) begin
      bad++; $display("FAIL sw_ops got a=%h b=%h st=%h exp 7/4/1234", id_a, id_b, id_st); end
    total++; if (id_wen !== 1'b0 || id_mem_wr !== 1'b1 || id_mem_rd !== 1'b0) begin
      bad++; $display("FAIL sw_ctrl got wen=%b wr=%b rd=%b exp 0/1/0", id_wen, id_mem_wr, id_mem_rd); end
    ir = 32'h00A5_0021;   // ADDU r0,r5,r5
    step();
    total++; if (id_wen !== 1'b0 || id_dest !== 5'd0) begin
      bad++; $display("FAIL r0_dest got wen=%b dest=%0d exp 0/0", id_wen, id_dest); end
    ir = 32'h0;
    step();
  endtask

  task automatic test_reset_illegal();
    ir = 32'h00A0_1821;   // ADDU r3,r5,r0 in flight
    step();
    rst = 1'b0;
    wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_DEAD;
    ir = 32'h0800_0010;   // J during reset
    #1;
    total++; if (jump !== 1'b0) begin bad++; $display("FAIL mid_rst_jump got=%b exp=0", jump); end
    step();
    wb_wen = 1'b0;
    total++; if (id_a !== 32'h0 || id_dest !== 5'd0 || id_wen !== 1'b0 || id_op !== 4'd0) begin
      bad++; $display("FAIL mid_rst_bundle got a=%h dest=%0d wen=%b op=%0d exp all 0", id_a, id_dest, id_wen, id_op); end
    rst = 1'b1;
    ir = 32'hFC00_0000;   // reserved opcode 0x3F
    #1;
    total++; if (jump !== 1'b0) begin bad++; $display("FAIL ill_jump got=%b exp=0", jump); end
    step();
    total++; if (id_illegal !== 1'b1 || id_wen !== 1'b0 || id_op !== 4'd0) begin
      bad++; $display("FAIL ill_op got ill=%b wen=%b op=%0d exp 1/0/0", id_illegal, id_wen, id_op); end
    ir = 32'h00A0_1821;
    step();
    total++; if (id_illegal !== 1'b0) begin bad++; $display("FAIL ill_one_cycle got=%b exp=0", id_illegal); end
    total++; if (id_a !== 32'h0000_1234) begin bad++; $display("FAIL rst_wr_ignored got=%h exp=00001234", id_a); end
    ir = 32'h0000_003F;   // SPECIAL with reserved funct
    step();
    total++; if (id_illegal !== 1'b1 || id_wen !== 1'b0) begin
      bad++; $display("FAIL ill_funct got ill=%b wen=%b exp 1/0", id_illegal, id_wen); end
    ir = 32'h0;
    step();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    pc      = 32'h0;
    ir      = 32'h0;
    wb_wen  = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'h0;
    ex_wen  = 1'b0;
    ex_addr = 5'd0;
    ex_data = 32'h0;
    step();
    test_reset();
    test_write_through();
    test_branch();
    test_jal();
    test_forward();
    test_imm();
    test_reset_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: WORD_WIDTH, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock; the only clock.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 pc  in  32  fetch PC; equals the address of ir plus 1, word-addressed.
REQ-005 ir  in  32  instruction from fetch; 0 (SLL r0,r0,0) is a NOP.
REQ-006 jump  out  1  redirect request to fetch; combinational.
REQ-007 target  out  32  redirect word address; combinational.
REQ-008 wb_wen / wb_addr / wb_data  in  1/5/32  register-file write port from writeback.
REQ-009 ex_wen / ex_addr / ex_data  in  1/5/32  execute-stage result, used for forwarding.
REQ-010 id_op  out  4  ALU operation; encoding defined in the package.
REQ-011 id_a / id_b  out  32/32  ALU operands.
REQ-012 id_st  out  32  store data (rt value).
REQ-013 id_dest / id_wen  out  5/1  destination register and write enable.
REQ-014 id_mem_rd / id_mem_wr  out  1/1  load / store.
REQ-015 id_illegal  out  1  reserved instruction decoded.

Function
REQ-016 Supported instructions: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-017 Immediate handling: zero-extended for ANDI/ORI/XORI; {imm,16'h0} for LUI; sign-extended for all other I-type instructions.
REQ-018 Shift instructions: id_a = {27'b0,shamt} and id_b = rt.
REQ-019 Other instructions: id_a = rs and id_b = rt (R-type) or the immediate (I-type).
REQ-020 Source operand priority: r0 always reads 0; otherwise ex forward (ex_wen and ex_addr match) wins over wb forward, and wb forward wins over the register-file value.
REQ-021 All id_* outputs are registered and update every cycle; decode-to-execute latency is 1 cycle; decode never stalls.
REQ-022 jump = 1 in each of these cases: J or JAL; JR or JALR; BEQ with rs==rt; BNE with rs!=rt. Comparisons use forwarded operands.
REQ-023 target for J/JAL = {pc[31:26], ir[25:0]}.
REQ-024 target for JR/JALR = forwarded rs.
REQ-025 target for a taken branch = pc + sext(imm), modulo 2^32.
REQ-026 When jump = 0, target = 0.
REQ-027 The instruction after any jump executes as the delay slot; decode does not flush or annul it.
REQ-028 Link: JAL writes pc+1 to r31; JALR writes pc+1 to rd; the link value is presented on id_a with id_op = PASS_A.
REQ-029 LW/SW: id_op = ADD, with id_a = rs and id_b = sext(imm); LW dest = rt; SW has id_wen = 0.
REQ-030 id_wen is forced to 0 whenever the destination is r0.
REQ-031 An unsupported opcode or funct produces a NOP bundle with id_illegal = 1 for one cycle, and jump = 0.
REQ-032 Load-use hazards are not interlocked; software respects the MIPS-I load delay slot.
REQ-033 Register file: a write with wb_wen = 1 commits at the clock edge; a same-cycle read of the same register returns wb_data.

Reset
REQ-034 While rst = 0, at each edge all id_* outputs are set to 0, which forms a NOP bundle.
REQ-035 While rst = 0, jump is held at 0 and register-file writes are ignored.
REQ-036 Register-file contents are not reset; r0 reads 0 at all times.
REQ-037 When rst is asserted mid-operation, the in-flight bundle is discarded on the next edge.

Structure
REQ-038 Package decode_pkg holds: the opcode and funct constants, the 4-bit ALU op encoding (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, PASS_A), and the r31 constant.
REQ-039 Sub-module regfile: 32x32, two asynchronous read ports, one synchronous write port, with write-through bypass.

Verification
REQ-040 Write-through: wb writes r5 = 32'h1234 in the same cycle that ir = ADDU r3,r5,r0 → on the next cycle id_a = 32'h1234, id_dest = 3, id_wen = 1.
REQ-041 Taken branch: pc = 32'h10, ir = BEQ r1,r2,-4 with r1 = r2 = 7 → jump = 1, target = 32'h0C; with r2 = 8 → jump = 0, target = 0.
REQ-042 Jump and link: pc = 32'h8000_0041, ir = JAL 26'h0000_100 → jump = 1, target = 32'h8000_0100; next cycle id_dest = 31, id_a = 32'h8000_0042.
REQ-043 Forwarding priority: ex and wb both target r4, with ex_data = 1 and wb_data = 2, ir = JR r4 → target = 1.
REQ-044 Reset and illegal: rst = 0 mid-stream → next cycle all id_* = 0 and jump = 0; after release, an illegal opcode 6'h3F → id_illegal = 1 for one cycle and id_wen = 0.
